// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared types, constants and helpers for the d_cache_v2 data cache.
//   - state_t      : controller states
//   - STRB_*       : store strobe encodings the cache accepts
//   - calc_ow/iw/tw: offset/index/tag widths derived from the geometry parameters
//   - strobe_legal : tests a store strobe against the accepted set
//   - lane_data    : places low-aligned store data onto the strobed byte lanes
package d_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REFILL = 3'd1,
        ST_WRITE  = 3'd2,
        ST_BYPASS = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b1100;
    localparam logic [3:0] STRB_W  = 4'b1111;

    function automatic int unsigned calc_ow(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned calc_iw(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned calc_tw(input int unsigned num_lines,
                                            input int unsigned line_words);
        return 30 - calc_ow(line_words) - calc_iw(num_lines);
    endfunction

    function automatic logic strobe_legal(input logic [3:0] strb);
        logic ok;
        case (strb)
            STRB_B0, STRB_B1, STRB_B2, STRB_B3,
            STRB_H0, STRB_H1, STRB_W: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Store data arrives low-aligned; move the byte/half into the strobed lane
    // and zero the lanes that are not written.
    function automatic logic [31:0] lane_data(input logic [3:0] strb, input logic [31:0] d);
        logic [31:0] r;
        case (strb)
            STRB_B0: r = {24'h00_0000, d[7:0]};
            STRB_B1: r = {16'h0000, d[7:0], 8'h00};
            STRB_B2: r = {8'h00, d[7:0], 16'h0000};
            STRB_B3: r = {d[7:0], 24'h00_0000};
            STRB_H0: r = {16'h0000, d[15:0]};
            STRB_H1: r = {d[15:0], 16'h0000};
            STRB_W:  r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/d_cache_line_ram.sv
// d_cache_line_ram: line data storage, NUM_LINES x LINE_WORDS words of 4 byte lanes.
//   clk, rst            : clock, synchronous active-high reset (read register only)
//   wr_en, wr_lane      : write strobe and per-byte-lane enables
//   wr_addr, wr_data    : word address {index, offset} and write data
//   rd_en, rd_addr      : read strobe and word address
//   rd_data             : registered read data, holds between reads
module d_cache_line_ram #(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned AW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [3:0]    wr_lane,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    localparam int unsigned DEPTH = NUM_LINES * LINE_WORDS;

    logic [3:0][7:0] mem_r [DEPTH];
    logic [31:0]     rd_data_r;

    // Byte-lane write port; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_lane[l]) begin
                    mem_r[wr_addr][l] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    // Registered read; the output holds its value until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/d_cache_v2.sv
// d_cache_v2: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst                         : clock, synchronous active-high reset
//   data_enable/data_read            : core request valid / 1=load 0=store
//   mem_wstrb, ram_address, ram_store: store strobes, byte address, low-aligned store data
//   ram_fetch, d_cache_miss          : load data, combinational stall
//   flush                            : invalidate all lines (acted on in IDLE)
//   set_*/_we/get_*                  : cacheable window base/bound write and readback
//   mem_req/we/addr/wdata/be         : registered memory request, held until mem_ack
//   mem_ack, mem_rdata               : memory completion and read data
module d_cache_v2
    import d_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_enable,
    input  logic        data_read,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] ram_address,
    input  logic [31:0] ram_store,
    output logic [31:0] ram_fetch,
    output logic        d_cache_miss,
    input  logic        flush,
    input  logic [31:0] set_base_addr,
    input  logic [31:0] set_bound_addr,
    input  logic        base_addr_we,
    input  logic        bound_addr_we,
    output logic [31:0] get_base_addr,
    output logic [31:0] get_bound_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OW         = calc_ow(LINE_WORDS);
    localparam int unsigned IW         = calc_iw(NUM_LINES);
    localparam int unsigned TW         = calc_tw(NUM_LINES, LINE_WORDS);
    localparam int unsigned AW         = IW + OW;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

    state_t          state_r;
    logic [NUM_LINES-1:0] valid_r;
    logic [TW-1:0]   tag_r [NUM_LINES];
    logic [31:0]     base_r;
    logic [31:0]     bound_r;
    logic [31:0]     req_addr_r;
    logic [31:0]     bypass_data_r;
    logic            fetch_sel_r;
    logic            flush_pend_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [31:0]     mem_addr_r;
    logic [31:0]     mem_wdata_r;
    logic [3:0]      mem_be_r;

    logic [IW-1:0]   in_idx_s;
    logic [TW-1:0]   in_tag_s;
    logic            in_cacheable_s;
    logic            in_hit_s;
    logic [IW-1:0]   wr_idx_s;
    logic [TW-1:0]   wr_tag_s;
    logic            wr_cacheable_s;
    logic            wr_hit_s;
    logic            last_word_s;
    logic            flush_eff_s;
    logic            hit_load_s;
    logic            illegal_st_s;
    logic            stall_s;
    logic            tag_we_s;
    logic            ram_we_s;
    logic [3:0]      ram_lane_s;
    logic [31:0]     ram_wdata_s;
    logic            ram_re_s;
    logic [31:0]     ram_rd_data_s;

    // Lookup for the incoming core request and for the line addressed by the
    // memory port (refill target / write-through target).
    always_comb begin
        in_idx_s       = ram_address[2+OW +: IW];
        in_tag_s       = ram_address[2+OW+IW +: TW];
        in_cacheable_s = (ram_address >= base_r) && (ram_address <= bound_r);
        in_hit_s       = valid_r[in_idx_s] && (tag_r[in_idx_s] == in_tag_s);
        wr_idx_s       = mem_addr_r[2+OW +: IW];
        wr_tag_s       = mem_addr_r[2+OW+IW +: TW];
        wr_cacheable_s = (req_addr_r >= base_r) && (req_addr_r <= bound_r);
        wr_hit_s       = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);
        // mem_addr_r walks the line during refill, so its offset bits are k.
        last_word_s    = ((mem_addr_r[2 +: AW] & AW'(LINE_WORDS - 1)) == AW'(LINE_WORDS - 1));
    end

    // Request classification and the combinational stall.
    always_comb begin
        flush_eff_s  = flush | flush_pend_r;
        hit_load_s   = data_enable & data_read & in_cacheable_s & in_hit_s;
        illegal_st_s = data_enable & ~data_read & ~strobe_legal(mem_wstrb);
        case (state_r)
            ST_IDLE: stall_s = flush_eff_s | (data_enable & ~hit_load_s & ~illegal_st_s);
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b1;
        endcase
    end

    // Line RAM port control: refill writes whole words, write-through hits
    // merge only the strobed lanes, loads read only on a serviced hit.
    always_comb begin
        ram_re_s = (state_r == ST_IDLE) & ~flush_eff_s & hit_load_s;
        tag_we_s = (state_r == ST_REFILL) & mem_ack & last_word_s;
        if (state_r == ST_REFILL) begin
            ram_we_s    = mem_ack;
            ram_lane_s  = 4'b1111;
            ram_wdata_s = mem_rdata;
        end else if (state_r == ST_WRITE) begin
            ram_we_s    = mem_ack & wr_cacheable_s & wr_hit_s;
            ram_lane_s  = mem_be_r;
            ram_wdata_s = mem_wdata_r;
        end else begin
            ram_we_s    = 1'b0;
            ram_lane_s  = 4'b0000;
            ram_wdata_s = 32'h0000_0000;
        end
    end

    // Tag array: written once, together with the valid bit, on the last refill ack.
    always_ff @(posedge clk) begin
        if (tag_we_s) begin
            tag_r[wr_idx_s] <= wr_tag_s;
        end
    end

    // Controller FSM, window registers, valid bits and registered memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            valid_r       <= '0;
            base_r        <= 32'h0000_0000;
            bound_r       <= 32'hFFFF_FFFF;
            req_addr_r    <= 32'h0000_0000;
            bypass_data_r <= 32'h0000_0000;
            fetch_sel_r   <= 1'b0;
            flush_pend_r  <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_be_r      <= 4'b0000;
        end else begin
            if (base_addr_we) begin
                base_r <= set_base_addr;
            end
            if (bound_addr_we) begin
                bound_r <= set_bound_addr;
            end
            // A flush seen outside IDLE is remembered and acted on back in IDLE.
            if (flush && (state_r != ST_IDLE)) begin
                flush_pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (flush_eff_s) begin
                        valid_r      <= '0;
                        flush_pend_r <= 1'b0;
                    end else if (data_enable && data_read) begin
                        if (in_cacheable_s && in_hit_s) begin
                            fetch_sel_r <= 1'b0;
                        end else if (in_cacheable_s) begin
                            state_r     <= ST_REFILL;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= ram_address & ~(32'(LINE_BYTES) - 32'd1);
                            mem_be_r    <= 4'b1111;
                            mem_wdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ST_BYPASS;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= {ram_address[31:2], 2'b00};
                            mem_be_r    <= 4'b1111;
                            mem_wdata_r <= 32'h0000_0000;
                        end
                    end else if (data_enable && strobe_legal(mem_wstrb)) begin
                        state_r     <= ST_WRITE;
                        req_addr_r  <= ram_address;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= {ram_address[31:2], 2'b00};
                        mem_be_r    <= mem_wstrb;
                        mem_wdata_r <= lane_data(mem_wstrb, ram_store);
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        if (last_word_s) begin
                            valid_r[wr_idx_s] <= 1'b1;
                            mem_req_r         <= 1'b0;
                            state_r           <= ST_IDLE;
                        end else begin
                            mem_addr_r <= mem_addr_r + 32'd4;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        state_r   <= ST_DONE;
                    end
                end
                ST_BYPASS: begin
                    if (mem_ack) begin
                        bypass_data_r <= mem_rdata;
                        fetch_sel_r   <= 1'b1;
                        mem_req_r     <= 1'b0;
                        state_r       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    d_cache_line_ram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .AW         (AW)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we_s),
        .wr_lane (ram_lane_s),
        .wr_addr (mem_addr_r[2 +: AW]),
        .wr_data (ram_wdata_s),
        .rd_en   (ram_re_s),
        .rd_addr (ram_address[2 +: AW]),
        .rd_data (ram_rd_data_s)
    );

    // Load data comes from the line RAM after a hit, or from the bypass register.
    assign ram_fetch      = fetch_sel_r ? bypass_data_r : ram_rd_data_s;
    assign d_cache_miss   = stall_s;
    assign get_base_addr  = base_r;
    assign get_bound_addr = bound_r;
    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign mem_be         = mem_be_r;

endmodule

// File: tb/tb_d_cache_v2.sv
// tb_d_cache_v2: directed self-checking bench for d_cache_v2 (64 lines x 4 words).
// Backing memory word at byte address A starts as 32'hD000_0000 ^ A.
module tb_d_cache_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_enable;
    logic        data_read;
    logic [3:0]  mem_wstrb;
    logic [31:0] ram_address;
    logic [31:0] ram_store;
    logic [31:0] ram_fetch;
    logic        d_cache_miss;
    logic        flush;
    logic [31:0] set_base_addr;
    logic [31:0] set_bound_addr;
    logic        base_addr_we;
    logic        bound_addr_we;
    logic [31:0] get_base_addr;
    logic [31:0] get_bound_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [4096];
    logic [31:0] rd_q [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    d_cache_v2 #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_enable    (data_enable),
        .data_read      (data_read),
        .mem_wstrb      (mem_wstrb),
        .ram_address    (ram_address),
        .ram_store      (ram_store),
        .ram_fetch      (ram_fetch),
        .d_cache_miss   (d_cache_miss),
        .flush          (flush),
        .set_base_addr  (set_base_addr),
        .set_bound_addr (set_bound_addr),
        .base_addr_we   (base_addr_we),
        .bound_addr_we  (bound_addr_we),
        .get_base_addr  (get_base_addr),
        .get_bound_addr (get_bound_addr),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after ack_delay waiting cycles, drives on the falling edge.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            if (mem_we) begin
                wr_cnt++;
                last_wr_addr = mem_addr;
                last_be      = mem_be;
                last_wdata   = mem_wdata;
                for (int l = 0; l < 4; l++) begin
                    if (mem_be[l]) mem_model[mem_addr[13:2]][8*l +: 8] = mem_wdata[8*l +: 8];
                end
            end else begin
                mem_rdata = mem_model[mem_addr[13:2]];
                rd_q.push_back(mem_addr);
            end
        end else begin
            mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // One core access; returns stalled cycles, or -1 if it never completes.
    // Call #1 after a rising edge; returns #1 after the completing edge.
    task automatic do_access(input logic rd, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wd, output int stalls);
        logic done;
        data_enable = 1'b1;
        data_read   = rd;
        ram_address = addr;
        mem_wstrb   = strb;
        ram_store   = wd;
        stalls      = 0;
        done        = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!d_cache_miss) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
        end
        if (!done) stalls = -1;
        @(posedge clk);
        #1;
        data_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (ram_fetch !== 32'h0) begin errors++; $display("FAIL reset_fetch: got %h expected %h", ram_fetch, 32'h0); end
        checks++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b expected %b", {mem_req, mem_we, mem_be}, 6'b0); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_data: got %h expected %h", {mem_addr, mem_wdata}, 64'h0); end
        checks++; if (get_base_addr !== 32'h0) begin errors++; $display("FAIL reset_base: got %h expected %h", get_base_addr, 32'h0); end
        checks++; if (get_bound_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_bound: got %h expected %h", get_bound_addr, 32'hFFFF_FFFF); end
        checks++; if (d_cache_miss !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", d_cache_miss, 1'b0); end
    endtask

    task automatic test_refill_hit();
        int st;
        rd_q.delete();
        do_access(1'b1, 32'h0000_0100, 4'b0000, 32'h0, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL refill_stall: got %0d expected %0d", st, 5); end
        checks++; if (ram_fetch !== 32'hD000_0100) begin errors++; $display("FAIL refill_data: got %h expected %h", ram_fetch, 32'hD000_0100); end
        checks++; if (rd_q.size() !== 4) begin errors++; $display("FAIL refill_reads: got %0d expected %0d", rd_q.size(), 4); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q.size() <= i || rd_q[i] !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL refill_addr%0d: got %h expected %h", i, (rd_q.size() > i) ? rd_q[i] : 32'hX, 32'h100 + 32'(4 * i));
            end
        end
        do_access(1'b1, 32'h0000_0104, 4'b0000, 32'h0, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL hit_stall: got %0d expected %0d", st, 0); end
        checks++; if (ram_fetch !== 32'hD000_0104) begin errors++; $display("FAIL hit_data: got %h expected %h", ram_fetch, 32'hD000_0104); end
    endtask

    task automatic test_store_merge();
        int st;
        int w0;
        w0 = wr_cnt;
        do_access(1'b0, 32'h0000_0108, 4'b0100, 32'h0000_00AB, st);
        checks++; if (st !== 2) begin errors++; $display("FAIL store_stall: got %0d expected %0d", st, 2); end
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL store_count: got %0d expected %0d", wr_cnt, w0 + 1); end
        checks++; if (last_be !== 4'b0100) begin errors++; $display("FAIL store_be: got %b expected %b", last_be, 4'b0100); end
        checks++; if (last_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL store_wdata: got %h expected %h", last_wdata, 32'h00AB_0000); end
        checks++; if (last_wr_addr !== 32'h0000_0108) begin errors++; $display("FAIL store_addr: got %h expected %h", last_wr_addr, 32'h0000_0108); end
        do_access(1'b1, 32'h0000_0108, 4'b0000, 32'h0, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL merge_stall: got %0d expected %0d", st, 0); end
        checks++; if (ram_fetch !== 32'hD0AB_0108) begin errors++; $display("FAIL merge_data: got %h expected %h", ram_fetch, 32'hD0AB_0108); end
    endtask

    task automatic test_store_no_allocate();
        int st;
        int w0;
        int r0;
        w0 = wr_cnt;
        do_access(1'b0, 32'h0000_2000, 4'b1111, 32'h1234_5678, st);
        checks++; if (st !== 2) begin errors++; $display("FAIL noalloc_stall: got %0d expected %0d", st, 2); end
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL noalloc_count: got %0d expected %0d", wr_cnt, w0 + 1); end
        r0 = rd_q.size();
        do_access(1'b1, 32'h0000_2000, 4'b0000, 32'h0, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL noalloc_miss: got %0d expected %0d", st, 5); end
        checks++; if (rd_q.size() !== r0 + 4) begin errors++; $display("FAIL noalloc_reads: got %0d expected %0d", rd_q.size(), r0 + 4); end
        checks++; if (ram_fetch !== 32'h1234_5678) begin errors++; $display("FAIL noalloc_data: got %h expected %h", ram_fetch, 32'h1234_5678); end
    endtask

    task automatic test_bypass();
        int st;
        int r0;
        set_base_addr  = 32'h0000_0000;
        set_bound_addr = 32'h0000_0FFF;
        base_addr_we   = 1'b1;
        bound_addr_we  = 1'b1;
        @(posedge clk);
        #1;
        base_addr_we  = 1'b0;
        bound_addr_we = 1'b0;
        checks++; if (get_bound_addr !== 32'h0000_0FFF) begin errors++; $display("FAIL bound_wr: got %h expected %h", get_bound_addr, 32'h0000_0FFF); end
        checks++; if (get_base_addr !== 32'h0) begin errors++; $display("FAIL base_wr: got %h expected %h", get_base_addr, 32'h0); end
        r0 = rd_q.size();
        do_access(1'b1, 32'h0000_1000, 4'b0000, 32'h0, st);
        checks++; if (st !== 2) begin errors++; $display("FAIL bypass_stall: got %0d expected %0d", st, 2); end
        checks++; if (rd_q.size() !== r0 + 1) begin errors++; $display("FAIL bypass_reads: got %0d expected %0d", rd_q.size(), r0 + 1); end
        checks++; if (ram_fetch !== 32'hD000_1000) begin errors++; $display("FAIL bypass_data: got %h expected %h", ram_fetch, 32'hD000_1000); end
        set_bound_addr = 32'hFFFF_FFFF;
        bound_addr_we  = 1'b1;
        @(posedge clk);
        #1;
        bound_addr_we = 1'b0;
        do_access(1'b1, 32'h0000_1000, 4'b0000, 32'h0, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL bypass_not_alloc: got %0d expected %0d", st, 5); end
    endtask

    task automatic test_reset_mid_refill();
        int st;
        int r0;
        ack_delay = 3;
        r0 = rd_q.size();
        data_enable = 1'b1;
        data_read   = 1'b1;
        ram_address = 32'h0000_0300;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (rd_q.size() >= r0 + 2) break;
        end
        #1;
        checks++; if (rd_q.size() !== r0 + 2) begin errors++; $display("FAIL midrst_acks: got %0d expected %0d", rd_q.size(), r0 + 2); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before: got %b expected %b", mem_req, 1'b1); end
        rst         = 1'b1;
        data_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req_after: got %b expected %b", mem_req, 1'b0); end
        r0 = rd_q.size();
        do_access(1'b1, 32'h0000_0300, 4'b0000, 32'h0, st);
        checks++; if (st !== 17) begin errors++; $display("FAIL midrst_reload_stall: got %0d expected %0d", st, 17); end
        checks++; if (rd_q.size() !== r0 + 4) begin errors++; $display("FAIL midrst_reload_reads: got %0d expected %0d", rd_q.size(), r0 + 4); end
        checks++; if (ram_fetch !== 32'hD000_0300) begin errors++; $display("FAIL midrst_reload_data: got %h expected %h", ram_fetch, 32'hD000_0300); end
        do_access(1'b1, 32'h0000_030C, 4'b0000, 32'h0, st);
        checks++; if (ram_fetch !== 32'hD000_030C || st !== 0) begin errors++; $display("FAIL midrst_hit: got %h/%0d expected %h/%0d", ram_fetch, st, 32'hD000_030C, 0); end
        ack_delay = 0;
    endtask

    task automatic test_flush_illegal();
        int st;
        int w0;
        int r0;
        do_access(1'b1, 32'h0000_0100, 4'b0000, 32'h0, st);
        do_access(1'b1, 32'h0000_0100, 4'b0000, 32'h0, st);
        checks++; if (st !== 0 || ram_fetch !== 32'hD000_0100) begin errors++; $display("FAIL preflush_hit: got %h/%0d expected %h/%0d", ram_fetch, st, 32'hD000_0100, 0); end
        flush       = 1'b1;
        data_enable = 1'b1;
        data_read   = 1'b1;
        ram_address = 32'h0000_0104;
        @(negedge clk);
        checks++; if (d_cache_miss !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b expected %b", d_cache_miss, 1'b1); end
        @(posedge clk);
        #1;
        flush       = 1'b0;
        data_enable = 1'b0;
        checks++; if (ram_fetch !== 32'hD000_0100) begin errors++; $display("FAIL flush_no_service: got %h expected %h", ram_fetch, 32'hD000_0100); end
        w0 = wr_cnt;
        do_access(1'b0, 32'h0000_0100, 4'b0101, 32'hFFFF_FFFF, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL illegal_stall: got %0d expected %0d", st, 0); end
        checks++; if (mem_req !== 1'b0 || wr_cnt !== w0) begin errors++; $display("FAIL illegal_no_req: got %b/%0d expected %b/%0d", mem_req, wr_cnt, 1'b0, w0); end
        r0 = rd_q.size();
        do_access(1'b1, 32'h0000_0100, 4'b0000, 32'h0, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL flush_miss: got %0d expected %0d", st, 5); end
        checks++; if (rd_q.size() !== r0 + 4 || ram_fetch !== 32'hD000_0100) begin errors++; $display("FAIL flush_refill: got %0d/%h expected %0d/%h", rd_q.size(), ram_fetch, r0 + 4, 32'hD000_0100); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'hD000_0000 ^ 32'(i * 4);
        mem_ack        = 1'b0;
        mem_rdata      = 32'h0;
        data_enable    = 1'b0;
        data_read      = 1'b0;
        mem_wstrb      = 4'b0000;
        ram_address    = 32'h0;
        ram_store      = 32'h0;
        flush          = 1'b0;
        set_base_addr  = 32'h0;
        set_bound_addr = 32'h0;
        base_addr_we   = 1'b0;
        bound_addr_we  = 1'b0;
        test_reset();
        test_refill_hit();
        test_store_merge();
        test_store_no_allocate();
        test_bypass();
        test_reset_mid_refill();
        test_flush_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
